// File: rtl/uart_pkg.sv
// Shared UART types and helpers, used by the TX path and reusable by RX.
// Holds frame-format enums, data-width limits and config decode functions.
package uart_pkg;

  localparam int MIN_DATA_BITS = 5;
  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    EVEN = 2'b01,
    ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } tx_state_e;

  // Anything outside the legal range falls back to the widest frame the instance supports.
  function automatic logic [3:0] clamp_data_bits(input logic [3:0] req, input int max_bits);
    if (int'(req) < MIN_DATA_BITS || int'(req) > max_bits || int'(req) > MAX_DATA_BITS)
      return 4'(max_bits);
    return req;
  endfunction

  function automatic parity_e decode_parity(input logic [1:0] raw);
    case (raw)
      2'b01:   return EVEN;
      2'b10:   return ODD;
      default: return NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side valid/ready word channel into the UART transmitter.
// Master drives valid/data, slave returns ready.
interface uart_tx_fifo_if #(
  parameter int DATA_W = 8
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; read data is registered on the pop edge and held until the next pop.
// Latency: a push is visible through empty/level one cycle later; push while full is dropped.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is not reset: clearing the pointers is enough to discard contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a word FIFO; frame format is latched per frame on the edge entering START.
// Bits advance only on baud_tick; producer is stalled through s_ready while the FIFO is full.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              baud_tick,
  uart_tx_fifo_if.slave                     s_if,
  input  logic [3:0]                        cfg_data_bits,
  input  logic [1:0]                        cfg_parity,
  input  logic                              cfg_stop2,
  output logic                              tx,
  output logic                              busy,
  output logic                              tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;

  tx_state_e  state, state_nxt;
  logic [3:0] bit_idx, bit_idx_nxt;
  logic [3:0] nbits_q;
  parity_e    par_q;
  logic       stop2_q;
  logic       tx_nxt;
  logic       done_nxt;
  logic       frame_end;
  logic       next_bit;
  logic       parity_bit;
  logic       par_x;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (s_if.s_valid && s_if.s_ready),
    .wr_data (s_if.s_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign s_if.s_ready = !fifo_full;
  assign busy         = (state != IDLE) || !fifo_empty;

  // fifo_rd_data doubles as the frame data register: it only changes on a pop.
  always_comb begin
    next_bit = 1'b0;
    par_x    = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (int'(bit_idx) + 1 == i) next_bit = fifo_rd_data[i];
      if (i < int'(nbits_q))      par_x    = par_x ^ fifo_rd_data[i];
    end
    parity_bit = (par_q == ODD) ? ~par_x : par_x;
  end

  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    tx_nxt      = tx;
    done_nxt    = 1'b0;
    fifo_pop    = 1'b0;
    frame_end   = 1'b0;
    if (baud_tick) begin
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state_nxt = START;
            tx_nxt    = 1'b0;
            fifo_pop  = 1'b1;
          end
        end
        START: begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
          tx_nxt      = fifo_rd_data[0];
        end
        DATA: begin
          if (bit_idx == nbits_q - 4'd1) begin
            if (par_q != NONE) begin
              state_nxt = PARITY;
              tx_nxt    = parity_bit;
            end else begin
              state_nxt = STOP1;
              tx_nxt    = 1'b1;
            end
          end else begin
            bit_idx_nxt = bit_idx + 4'd1;
            tx_nxt      = next_bit;
          end
        end
        PARITY: begin
          state_nxt = STOP1;
          tx_nxt    = 1'b1;
        end
        STOP1: begin
          if (stop2_q) begin
            state_nxt = STOP2;
            tx_nxt    = 1'b1;
          end else begin
            frame_end = 1'b1;
          end
        end
        STOP2: frame_end = 1'b1;
        default: begin
          state_nxt = IDLE;
          tx_nxt    = 1'b1;
        end
      endcase
      // Back-to-back frames: the ending tick is also the start bit of the next word.
      if (frame_end) begin
        done_nxt = 1'b1;
        if (!fifo_empty) begin
          state_nxt = START;
          tx_nxt    = 1'b0;
          fifo_pop  = 1'b1;
        end else begin
          state_nxt = IDLE;
          tx_nxt    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_idx <= '0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
      nbits_q <= 4'(DATA_W);
      par_q   <= NONE;
      stop2_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_idx <= bit_idx_nxt;
      tx      <= tx_nxt;
      tx_done <= done_nxt;
      if (fifo_pop) begin
        nbits_q <= clamp_data_bits(cfg_data_bits, DATA_W);
        par_q   <= decode_parity(cfg_parity);
        stop2_q <= cfg_stop2;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised and directed bench for uart_tx_fifo against a queue-of-bits frame model.
module tb_uart_tx_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int LW     = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          baud_tick = 1'b0;
  logic [3:0]    cfg_data_bits = 4'd8;
  logic [1:0]    cfg_parity = 2'd0;
  logic          cfg_stop2 = 1'b0;
  logic          tx;
  logic          busy;
  logic          tx_done;
  logic [LW-1:0] fifo_level;

  uart_tx_fifo_if #(.DATA_W(DATA_W)) s_if ();

  uart_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .baud_tick     (baud_tick),
    .s_if          (s_if),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .tx            (tx),
    .busy          (busy),
    .tx_done       (tx_done),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  // Model: words waiting in the FIFO, plus the bits still to be shifted for the frame on the line.
  int  mq[$];
  bit  bits[$];
  bit  m_active;
  bit  m_tx;
  bit  m_done;
  bit  chk_en;
  int  checks;
  int  errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_frame();
    int w, n, ones;
    w    = mq.pop_front();
    n    = (cfg_data_bits >= 5 && int'(cfg_data_bits) <= DATA_W) ? int'(cfg_data_bits) : DATA_W;
    ones = 0;
    bits.delete();
    for (int i = 0; i < n; i++) begin
      bits.push_back(bit'((w >> i) & 1));
      ones += (w >> i) & 1;
    end
    if (cfg_parity == 2'b01) bits.push_back(bit'(ones % 2));
    if (cfg_parity == 2'b10) bits.push_back(bit'(1 - ones % 2));
    bits.push_back(1'b1);
    if (cfg_stop2) bits.push_back(1'b1);
    m_tx     = 1'b0;
    m_active = 1'b1;
  endtask

  // Called with the inputs that the coming clock edge will sample.
  task automatic model_edge();
    bit can_push;
    m_done = 1'b0;
    if (!reset_n) begin
      mq.delete();
      bits.delete();
      m_active = 1'b0;
      m_tx     = 1'b1;
      return;
    end
    can_push = mq.size() < DEPTH;
    if (baud_tick) begin
      if (m_active && bits.size() > 0) begin
        m_tx = bits.pop_front();
      end else if (m_active || mq.size() > 0) begin
        if (m_active) m_done = 1'b1;
        if (mq.size() > 0) start_frame();
        else begin
          m_active = 1'b0;
          m_tx     = 1'b1;
        end
      end
    end
    if (s_if.s_valid && can_push) mq.push_back(int'(s_if.s_data));
  endtask

  task automatic compare_all();
    check("tx", 32'(tx), 32'(m_tx));
    check("tx_done", 32'(tx_done), 32'(m_done));
    check("busy", 32'(busy), 32'(m_active || mq.size() > 0));
    check("fifo_level", 32'(fifo_level), 32'(mq.size()));
    check("s_ready", 32'(s_if.s_ready), 32'(mq.size() < DEPTH));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    if (chk_en) compare_all();
  endtask

  task automatic set_cfg(input int nb, input int par, input int st2);
    cfg_data_bits = 4'(nb);
    cfg_parity    = 2'(par);
    cfg_stop2     = 1'(st2);
  endtask

  task automatic push_word(input int w);
    s_if.s_valid = 1'b1;
    s_if.s_data  = DATA_W'(w);
    baud_tick    = 1'b0;
    step();
    s_if.s_valid = 1'b0;
  endtask

  // Push one word into an idle block, record tx after every tick until tx_done, compare to a literal.
  task automatic send_capture(input int word, input logic [15:0] exp_vec, input int exp_len,
                              input string name);
    logic [15:0] cap;
    int          n;
    bit          done;
    cap  = '0;
    n    = 0;
    done = 1'b0;
    push_word(word);
    for (int c = 0; c < 600 && !done; c++) begin
      baud_tick = (c % 16 == 15);
      step();
      if (baud_tick) begin
        if (tx_done) done = 1'b1;
        else begin
          if (n < 16) cap[n] = tx;
          n++;
        end
      end
    end
    baud_tick = 1'b0;
    check({name, " done"}, 32'(done), 32'd1);
    check({name, " len"}, 32'(n), 32'(exp_len));
    check({name, " bits"}, 32'(cap), 32'(exp_vec));
    check({name, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int ticks, d1, d2, done_cnt;
    checks       = 0;
    errors       = 0;
    chk_en       = 1'b1;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;

    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    check("reset tx", 32'(tx), 32'd1);
    check("reset s_ready", 32'(s_if.s_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset tx_done", 32'(tx_done), 32'd0);
    check("reset level", 32'(fifo_level), 32'd0);
    repeat (2) step();

    set_cfg(8, 0, 0);
    send_capture(8'h55, 16'h02AA, 10, "8N1 0x55");
    set_cfg(8, 1, 0);
    send_capture(8'h07, 16'h060E, 11, "8E1 0x07");
    send_capture(8'h03, 16'h0406, 11, "8E1 0x03");
    set_cfg(7, 2, 1);
    send_capture(8'h7F, 16'h06FE, 11, "7O2 0x7F");

    // Fill past capacity with no ticks, then drain back-to-back.
    set_cfg(8, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      s_if.s_valid = 1'b1;
      s_if.s_data  = DATA_W'($urandom);
      step();
    end
    s_if.s_valid = 1'b0;
    check("full level", 32'(fifo_level), 32'd16);
    check("full s_ready", 32'(s_if.s_ready), 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 2000 && busy; c++) begin
      baud_tick = (c % 4 == 3);
      step();
      if (tx_done) done_cnt++;
    end
    baud_tick = 1'b0;
    check("drain frames", 32'(done_cnt), 32'd16);
    check("drain idle", 32'(busy), 32'd0);

    // Reset while the fourth data bit (bit 3 of 0xA5 = 0) is on the line.
    push_word(8'hA5);
    push_word(8'h3C);
    ticks = 0;
    for (int c = 0; c < 200 && ticks < 5; c++) begin
      baud_tick = (c % 8 == 7);
      step();
      if (baud_tick) ticks++;
    end
    baud_tick = 1'b0;
    check("mid-frame bit3", 32'(tx), 32'd0);
    reset_n = 1'b0;
    step();
    check("abort tx", 32'(tx), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    check("abort level", 32'(fifo_level), 32'd0);
    reset_n = 1'b1;
    step();
    send_capture(8'h55, 16'h02AA, 10, "post-reset 0x55");

    // Shrink the data width mid-frame: only the second frame uses 5 bits.
    set_cfg(8, 0, 0);
    push_word(8'hB3);
    push_word(8'h1F);
    ticks = 0;
    d1    = -1;
    d2    = -1;
    for (int c = 0; c < 1000 && d2 < 0; c++) begin
      baud_tick = (c % 8 == 7);
      step();
      if (baud_tick) begin
        ticks++;
        if (tx_done) begin
          if (d1 < 0) d1 = ticks;
          else d2 = ticks;
        end
        if (ticks == 3) cfg_data_bits = 4'd5;
      end
    end
    baud_tick = 1'b0;
    check("cfg frame1 ticks", 32'(d1), 32'd11);
    check("cfg frame2 ticks", 32'(d2 - d1), 32'd7);
    set_cfg(8, 0, 0);
    repeat (4) step();

    // Random traffic, formats (including out-of-range widths and parity 11) and tick spacing.
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0)
        set_cfg($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1));
      s_if.s_valid = ($urandom_range(0, 3) == 0);
      s_if.s_data  = DATA_W'($urandom);
      baud_tick    = ($urandom_range(0, 5) == 0);
      reset_n      = !(c == 2200);
      step();
    end
    reset_n      = 1'b1;
    s_if.s_valid = 1'b0;
    for (int c = 0; c < 3000 && busy; c++) begin
      baud_tick = (c % 2 == 1);
      step();
    end
    baud_tick = 1'b0;
    check("final idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
